// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DRW engine: XORs an n-row sprite from program RAM into a 64x32
// framebuffer (256 bytes, MSB = leftmost pixel), with wrap and collision.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; latches operands on acceptance
// SPR_RD  | ram_address = i_addr + r presented to program RAM
// SPR_CAP | sprite byte s captured from ram_q
// FB0_RD  | fb_address = row*8 + b0 presented
// FB0_CAP | fb_q ^ mask0 registered for write, collision accumulated
// FB0_WR  | fb_wren high for the left byte
// FB1_RD  | fb_address = row*8 + b1 presented
// FB1_CAP | fb_q ^ mask1 registered for write, collision accumulated
// FB1_WR  | fb_wren high for the right byte; next row or finish
// DONE    | one-cycle done pulse, busy low
module chip8_sprite_draw (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic [11:0] ram_address,
  input  logic [7:0]  ram_q,
  output logic [7:0]  fb_address,
  input  logic [7:0]  fb_q,
  output logic [7:0]  fb_data,
  output logic        fb_wren,
  output logic        busy,
  output logic        done,
  output logic        collision
);

  typedef enum logic [3:0] {
    IDLE, SPR_RD, SPR_CAP, FB0_RD, FB0_CAP, FB0_WR,
    FB1_RD, FB1_CAP, FB1_WR, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  r_q, r_d;
  logic [7:0]  s_q, s_d;
  logic [11:0] ram_address_q, ram_address_d;
  logic [7:0]  fb_address_q, fb_address_d;
  logic [7:0]  fb_data_q, fb_data_d;
  logic        fb_wren_q, fb_wren_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        collision_q, collision_d;

  // Upper coordinate bits are ignored; the screen is 64x32.
  logic        unused_coord_bits;
  assign unused_coord_bits = ^{x[7:6], y[7:5]};

  logic [15:0] mask16;
  logic [7:0]  mask0, mask1;
  logic [4:0]  row;
  logic [2:0]  b0, b1;

  // Pixel masks for the two framebuffer bytes a sprite row can straddle.
  always_comb begin
    mask16 = {s_q, 8'h00} >> x_q[2:0];
    mask0  = mask16[15:8];
    mask1  = mask16[7:0];
    row    = y_q + {1'b0, r_q};
    b0     = x_q[5:3];
    b1     = x_q[5:3] + 3'd1;
  end

  // Next-state logic; outputs are registered from the state being entered.
  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    n_d           = n_q;
    i_d           = i_q;
    r_d           = r_q;
    s_d           = s_q;
    ram_address_d = ram_address_q;
    fb_address_d  = fb_address_q;
    fb_data_d     = fb_data_q;
    fb_wren_d     = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    collision_d   = collision_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d         = x[5:0];
          y_d         = y[4:0];
          n_d         = n;
          i_d         = i_addr;
          r_d         = 4'd0;
          collision_d = 1'b0;
          if (n != 4'd0) begin
            state_d       = SPR_RD;
            busy_d        = 1'b1;
            ram_address_d = i_addr;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      SPR_RD:  state_d = SPR_CAP;
      SPR_CAP: begin
        s_d          = ram_q;
        state_d      = FB0_RD;
        fb_address_d = {row, b0};
      end
      FB0_RD:  state_d = FB0_CAP;
      FB0_CAP: begin
        state_d     = FB0_WR;
        fb_data_d   = fb_q ^ mask0;
        fb_wren_d   = 1'b1;
        collision_d = collision_q | (|(fb_q & mask0));
      end
      FB0_WR: begin
        state_d      = FB1_RD;
        fb_address_d = {row, b1};
      end
      FB1_RD:  state_d = FB1_CAP;
      FB1_CAP: begin
        state_d     = FB1_WR;
        fb_data_d   = fb_q ^ mask1;
        fb_wren_d   = 1'b1;
        collision_d = collision_q | (|(fb_q & mask1));
      end
      FB1_WR: begin
        if (r_q < n_q - 4'd1) begin
          r_d           = r_q + 4'd1;
          state_d       = SPR_RD;
          ram_address_d = i_q + {8'd0, r_q + 4'd1};
        end else begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any draw in progress.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      n_q           <= '0;
      i_q           <= '0;
      r_q           <= '0;
      s_q           <= '0;
      ram_address_q <= '0;
      fb_address_q  <= '0;
      fb_data_q     <= '0;
      fb_wren_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      collision_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      n_q           <= n_d;
      i_q           <= i_d;
      r_q           <= r_d;
      s_q           <= s_d;
      ram_address_q <= ram_address_d;
      fb_address_q  <= fb_address_d;
      fb_data_q     <= fb_data_d;
      fb_wren_q     <= fb_wren_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      collision_q   <= collision_d;
    end
  end

  assign ram_address = ram_address_q;
  assign fb_address  = fb_address_q;
  assign fb_data     = fb_data_q;
  assign fb_wren     = fb_wren_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign collision   = collision_q;

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Testbench for chip8_sprite_draw: behavioural RAMs, a pixel-level reference
// framebuffer and a scoreboard of expected done latency / collision per draw.
module tb_chip8_sprite_draw;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x, y;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic [11:0] ram_address;
  logic [7:0]  ram_q;
  logic [7:0]  fb_address;
  logic [7:0]  fb_q;
  logic [7:0]  fb_data;
  logic        fb_wren;
  logic        busy, done, collision;

  chip8_sprite_draw dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .x          (x),
    .y          (y),
    .n          (n),
    .i_addr     (i_addr),
    .ram_address(ram_address),
    .ram_q      (ram_q),
    .fb_address (fb_address),
    .fb_q       (fb_q),
    .fb_data    (fb_data),
    .fb_wren    (fb_wren),
    .busy       (busy),
    .done       (done),
    .collision  (collision)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [7:0] ram [4096];
  logic [7:0] fb [256] = '{default: 8'h00};
  logic [7:0] exp_fb [256] = '{default: 8'h00};

  // Synchronous RAMs: address/data/wren sampled at the edge, q valid next cycle.
  always @(posedge CLOCK_50) begin
    ram_q <= ram[ram_address];
    fb_q  <= fb[fb_address];
    if (fb_wren) fb[fb_address] <= fb_data;
  end

  int wr_cnt = 0;
  int done_cnt = 0;
  always @(posedge CLOCK_50) begin
    if (fb_wren) wr_cnt++;
    if (done) done_cnt++;
  end

  int passed = 0;
  int total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  typedef struct {
    string tag;
    int    cyc;
    logic  coll;
  } exp_t;
  exp_t sb[$];

  // Pixel-by-pixel reference draw into exp_fb.
  task automatic ref_draw(input int xx, input int yy, input int nn, input int ii,
                          output logic coll);
    logic [7:0] s;
    int px, py, idx, bt;
    coll = 1'b0;
    for (int r = 0; r < nn; r++) begin
      s = ram[(ii + r) % 4096];
      for (int c = 0; c < 8; c++) begin
        if (s[7-c]) begin
          px  = ((xx % 64) + c) % 64;
          py  = ((yy % 32) + r) % 32;
          idx = py * 8 + px / 8;
          bt  = 7 - (px % 8);
          if (exp_fb[idx][bt]) coll = 1'b1;
          exp_fb[idx][bt] = ~exp_fb[idx][bt];
        end
      end
    end
  endtask

  function automatic int fb_diffs();
    int d = 0;
    for (int k = 0; k < 256; k++) if (fb[k] !== exp_fb[k]) d++;
    return d;
  endfunction

  // One draw; optionally pulses a conflicting start at cycle 'glitch'.
  task automatic run_draw(input string tag, input int xx, input int yy, input int nn,
                          input int ii, input int glitch);
    logic coll;
    int   wr0, dn0, cycles;
    exp_t e;
    ref_draw(xx, yy, nn, ii, coll);
    sb.push_back('{tag, (nn == 0) ? 1 : 8 * nn + 1, coll});
    wr0 = wr_cnt;
    dn0 = done_cnt;
    x = 8'(xx); y = 8'(yy); n = 4'(nn); i_addr = 12'(ii);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    cycles = 1;
    check({tag, " busy"}, {31'd0, busy}, {31'd0, nn != 0});
    while (!done && cycles < 400) begin
      if (cycles == glitch) begin
        start = 1'b1; x = 8'd0; y = 8'd0; n = 4'd1; i_addr = 12'h050;
      end
      @(posedge CLOCK_50); #1;
      start = 1'b0;
      cycles++;
    end
    e = sb.pop_front();
    check({e.tag, " done seen"}, {31'd0, done}, 32'd1);
    check({e.tag, " latency"}, cycles, e.cyc);
    check({e.tag, " collision"}, {31'd0, collision}, {31'd0, e.coll});
    check({e.tag, " busy in done"}, {31'd0, busy}, 32'd0);
    check({e.tag, " write pulses"}, wr_cnt - wr0, 2 * nn);
    @(posedge CLOCK_50); #1;
    check({e.tag, " done single"}, {31'd0, done}, 32'd0);
    check({e.tag, " done count"}, done_cnt - dn0, 32'd1);
    check({e.tag, " fb image"}, fb_diffs(), 32'd0);
  endtask

  initial begin
    logic coll;
    int   wr0;
    for (int k = 0; k < 4096; k++) ram[k] = 8'h00;
    ram[12'h050] = 8'hF0;
    ram[12'h300] = 8'hFF;
    ram[12'h301] = 8'h81;
    ram[12'h400] = 8'hAA;
    ram[12'h401] = 8'h55;
    ram[12'h402] = 8'h3C;
    reset = 1'b1; start = 1'b0; x = '0; y = '0; n = '0; i_addr = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset outputs", {ram_address, fb_address, fb_data, fb_wren, busy, done, collision},
          32'd0);
    reset = 1'b0;
    @(posedge CLOCK_50); #1;

    run_draw("aligned", 0, 0, 1, 12'h050, -1);
    check("aligned fb0", {24'd0, fb[0]}, 32'hF0);
    check("aligned fb1", {24'd0, fb[1]}, 32'h00);

    run_draw("redraw", 0, 0, 1, 12'h050, -1);
    check("redraw fb0", {24'd0, fb[0]}, 32'h00);
    check("redraw collision", {31'd0, collision}, 32'd1);

    run_draw("n_zero", 5, 5, 0, 12'h050, -1);

    run_draw("wrap", 60, 31, 2, 12'h300, -1);
    check("wrap fb255", {24'd0, fb[255]}, 32'h0F);
    check("wrap fb248", {24'd0, fb[248]}, 32'hF0);
    check("wrap fb7", {24'd0, fb[7]}, 32'h08);
    check("wrap fb0", {24'd0, fb[0]}, 32'h10);

    run_draw("start_busy", 16, 10, 2, 12'h300, 5);
    check("start_busy fb82", {24'd0, fb[82]}, 32'hFF);
    check("start_busy fb90", {24'd0, fb[90]}, 32'h81);

    // Reset in FB0_WR of row 1 of a 3-row draw: only row 0 survives.
    ref_draw(8, 4, 1, 12'h400, coll);
    x = 8'd8; y = 8'd4; n = 4'd3; i_addr = 12'h400;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    repeat (12) @(posedge CLOCK_50);
    #1;
    check("pre-reset wren", {31'd0, fb_wren}, 32'd1);
    wr0 = wr_cnt;
    reset = 1'b1;
    #1;
    check("mid-draw reset outputs",
          {ram_address, fb_address, fb_data, fb_wren, busy, done, collision}, 32'd0);
    repeat (3) @(posedge CLOCK_50);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1;
    check("no write after reset", wr_cnt - wr0, 32'd0);
    check("reset fb33", {24'd0, fb[33]}, 32'hAA);
    check("reset fb41", {24'd0, fb[41]}, 32'h00);
    check("reset fb image", fb_diffs(), 32'd0);

    run_draw("post_reset", 8, 4, 3, 12'h400, -1);
    check("post_reset fb33", {24'd0, fb[33]}, 32'h00);
    check("post_reset fb41", {24'd0, fb[41]}, 32'h55);
    check("post_reset fb49", {24'd0, fb[49]}, 32'h3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
